// File: rtl/serial_framer_pkg.sv
// Shared types and line-level constants for the serial framer.
package definitions;

    // Frame sequencing states, in transmit order.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } framer_state_t;

    // Serial line levels.
    localparam logic LINE_IDLE = 1'b0;
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/serial_framer_handshake.sv
// Two-phase (toggle) handshake sink: owns the ack register and
// reports a pending request whenever req and ack disagree.
module tp_handshake_rx (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic accept,
    output logic ack,
    output logic pending
);

    // Toggle ack once for every accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack <= 1'b0;
        end else if (accept) begin
            ack <= ~ack;
        end
    end

    assign pending = req ^ ack;

endmodule

// File: rtl/serial_framer.sv
// Serial framer: start bit, MSB-first payload, even parity, stop bit,
// then a programmable idle gap. One word per two-phase handshake.
module serial_framer
    import definitions::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DATA_W-1:0] data,
    output logic              ack,
    output logic              dout,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    framer_state_t     state;
    framer_state_t     state_n;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_n;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_n;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_cnt_n;
    logic              par;
    logic              par_n;
    logic              dout_n;
    logic              accept;
    logic              pending;

    tp_handshake_rx u_hs (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .accept  (accept),
        .ack     (ack),
        .pending (pending)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-line-value decode. dout is registered, so the
    // level computed here appears on the line one edge later; this makes
    // the start bit visible right after the capture edge.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        par_n     = par;
        dout_n    = LINE_IDLE;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    accept    = 1'b1;
                    shreg_n   = data;
                    // Parity is latched with the word so later changes
                    // on data cannot corrupt the frame.
                    par_n     = ^data;
                    bit_cnt_n = '0;
                    dout_n    = START_BIT;
                    state_n   = START;
                end
            end
            START: begin
                dout_n    = shreg[DATA_W-1];
                shreg_n   = {shreg[DATA_W-2:0], 1'b0};
                bit_cnt_n = '0;
                state_n   = DATA;
            end
            DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    dout_n  = par;
                    state_n = PARITY;
                end else begin
                    dout_n    = shreg[DATA_W-1];
                    shreg_n   = {shreg[DATA_W-2:0], 1'b0};
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            PARITY: begin
                dout_n  = STOP_BIT;
                state_n = STOP;
            end
            STOP: begin
                dout_n = LINE_IDLE;
                if (GAP_CYCLES > 0) begin
                    gap_cnt_n = GAP_LOAD;
                    state_n   = GAP;
                end else begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                dout_n = LINE_IDLE;
                if (gap_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath and line registers; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            par     <= 1'b0;
            dout    <= LINE_IDLE;
        end else begin
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            gap_cnt <= gap_cnt_n;
            par     <= par_n;
            dout    <= dout_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/serial_framer.md
# serial_framer

Transmit-side framer directly upstream of the SerDes receive path: accepts one `DATA_W`-bit word per two-phase (toggle) request/acknowledge handshake and emits it on a single-bit serial line for the SerDes `din` input. Each frame is one start bit, the data MSB-first, even parity, one stop bit, then a programmable idle gap. It gives the system a self-contained bitstream source and is the stimulus stage for link-level tests.

## Interface
Parameters:
- `DATA_W`, 8, payload width in bits; minimum 2.
- `GAP_CYCLES`, 2, forced line-idle cycles after the stop bit; 0 is legal.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  1  two-phase request; a toggle announces a new word.
- `data`  in  `DATA_W`  payload; must be stable while `req != ack`.
- `ack`  out  1  two-phase acknowledge; toggles when `data` is captured.
- `dout`  out  1  serial line, registered; idle level 0.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Request pending ⇔ `req != ack`. `req` is same-clock; no synchronizer.
- FSM: IDLE → START → DATA → PARITY → STOP → GAP → IDLE. With `GAP_CYCLES = 0`, STOP → IDLE.
- IDLE: `dout = 0`. If a request is pending, capture `data` into the shift register, toggle `ack`, and go to START.
- START: `dout = 1`.
- DATA: `DATA_W` cycles, `dout = shreg[DATA_W-1]`, shift left by 1 each cycle. Bit counter is `$clog2(DATA_W)` bits, counts 0..`DATA_W-1`, then goes to PARITY.
- PARITY: `dout = ^captured_data` (even parity). This is computed at capture and held; it must not be derived from `data` live.
- STOP: `dout = 0`.
- GAP: `dout = 0` for `GAP_CYCLES` cycles, using a down-counter loaded with `GAP_CYCLES-1`.
- A `req` toggle during a frame stays pending and is served at the next IDLE. A second toggle before `ack` matches is a protocol violation: the word is lost and no recovery is required.
- Reset (any cycle, including mid-frame): state IDLE, `dout = 0`, `ack = 0`, `busy = 0`, shift register and counters 0. The partial frame is abandoned with no stop bit.
  - After reset, if `req = 1`, that counts as pending and is accepted in the first IDLE cycle.

## Timing
- Edge E0 (state IDLE, `req != ack`): `ack` toggles and `dout` becomes 1 (start), both visible after E0. Capture-to-acknowledge latency is 0 cycles beyond the sampling edge.
- After E1..E`DATA_W`: data bits, MSB first.
- After E`DATA_W+1`: parity. After E`DATA_W+2`: stop (0).
- Next `GAP_CYCLES` edges: GAP. The following edge: IDLE.
- Earliest next capture: E0 + `DATA_W + 4 + GAP_CYCLES`. With defaults, 14 cycles per word.
- `busy` is registered with the state: it rises at E0 and falls when IDLE is entered.
- Line is low for at least `GAP_CYCLES + 2` cycles between consecutive start bits.

## Structure
- In package `definitions`:
  - `framer_state_t` enum {IDLE, START, DATA, PARITY, STOP, GAP};
  - constants `LINE_IDLE = 1'b0`, `START_BIT = 1'b1`, `STOP_BIT = 1'b0`.
- Sub-module `tp_handshake_rx`: holds the `ack` register. It outputs `pending = req ^ ack` and toggles `ack` on an `accept` strobe from the FSM. It is reusable by other two-phase sinks in the design.
- The FSM, shift register, bit counter, gap counter and parity register live in `serial_framer`.

## Test plan
- Single word: reset, toggle `req` 0→1 with `data = 8'hA5` → `ack` toggles 0→1 at E0. `dout` after E0..E12 is 1, 1,0,1,0,0,1,0,1, 0 (parity), 0 (stop), 0, 0. Then IDLE, `busy` 0.
- Odd parity: `data = 8'h07` → parity bit 1. Also check that changing `data` after E0 does not alter the frame.
- Back-to-back: toggle `req` for `8'h3C`, and again immediately on `ack` for `8'hC3` → second start bit exactly 14 cycles after the first. `ack` toggles exactly twice.
- Pending during frame: toggle `req` at E5 of a frame → held until IDLE, then captured at the first IDLE edge. `dout` shows no glitch on the line.
- Mid-frame reset: assert `rst` for 1 cycle at E4 → `dout = 0`, `ack = 0`, `busy = 0` next cycle. With `req = 1` held, a new frame starts one cycle after reset deasserts.
- `GAP_CYCLES = 0`, `DATA_W = 4`: back-to-back `4'h9`, `4'h6` → period 8 cycles. Frames are 1,1001,0,0 and 1,0110,0,0.
